// File: rtl/vrased_reset_ctrl_if.sv
// ----------------------------------------------------------------------------
// vrased_reset_ctrl_if
// Bundles the monitor-facing request/PC/clear inputs and the reset/status
// outputs of vrased_reset_ctrl.
//   viol_req    : level reset requests, one bit per monitor
//   pc          : current CPU program counter
//   cause_clr   : one-cycle pulse requesting a cause/first_cause clear
//   sys_rst     : reset line to the CPU core
//   locked      : high while the controller is not idle
//   cause       : sticky OR of all requests since the last clear
//   first_cause : request bits captured when a reset sequence started
//   viol_cnt    : saturating count of violation events
// Modports: master = monitor/CPU side (drives requests), slave = controller.
// ----------------------------------------------------------------------------
interface vrased_reset_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    logic [NREQ-1:0]  viol_req;
    logic [15:0]      pc;
    logic             cause_clr;
    logic             sys_rst;
    logic             locked;
    logic [NREQ-1:0]  cause;
    logic [NREQ-1:0]  first_cause;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output viol_req, pc, cause_clr,
        input  sys_rst, locked, cause, first_cause, viol_cnt
    );

    modport slave (
        input  viol_req, pc, cause_clr,
        output sys_rst, locked, cause, first_cause, viol_cnt
    );
endinterface

// File: rtl/vrased_reset_ctrl.sv
// ----------------------------------------------------------------------------
// vrased_reset_ctrl
// Collects level reset requests from the security monitors and drives the CPU
// reset line for at least HOLD_CYCLES cycles, then stays locked until the CPU
// fetches from the reset handler. Keeps sticky cause bits, first-cause bits
// and a saturating violation-event counter for post-mortem inspection.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   bus         : vrased_reset_ctrl_if.slave (requests, pc, clear, status)
//   dbg_state_o : current FSM state, for observation only
// The controller has no handshake: requests are levels sampled every cycle,
// cause_clr is a single-cycle pulse, all outputs are registered.
// ----------------------------------------------------------------------------
module vrased_reset_ctrl #(
    parameter int          NREQ          = 4,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          CNT_W         = 8,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
    input  logic                 clk,
    input  logic                 rst,
    vrased_reset_ctrl_if.slave   bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_RH = 2'd2
    } state_t;

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic             req_any_q;
    logic             sys_rst_q, locked_q;
    logic [NREQ-1:0]  cause_q, cause_d;
    logic [NREQ-1:0]  first_cause_q, first_cause_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

    logic req_any;
    logic req_event;

    assign req_any   = |bus.viol_req;
    // A request held high for many cycles is one event; only rising edges count.
    assign req_event = req_any & ~req_any_q;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cause_d       = cause_q | bus.viol_req;
        first_cause_d = first_cause_q;
        viol_cnt_d    = viol_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // The clear overwrites rather than ORs, so a request arriving in
                // the same cycle as the clear is not lost.
                if (bus.cause_clr) begin
                    cause_d       = bus.viol_req;
                    first_cause_d = '0;
                end
                if (req_any) begin
                    state_d       = ST_HOLD;
                    hold_cnt_d    = HOLD_RELOAD;
                    first_cause_d = bus.viol_req;
                end
            end
            ST_HOLD: begin
                // A new event restarts the full pulse; a still-asserted request
                // at the end of the window extends it by another full window.
                if (req_event) begin
                    hold_cnt_d = HOLD_RELOAD;
                end else if (hold_cnt_q == '0) begin
                    if (req_any) begin
                        hold_cnt_d = HOLD_RELOAD;
                    end else begin
                        state_d = ST_WAIT_RH;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ST_WAIT_RH: begin
                if (req_any) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_RELOAD;
                end else if (bus.pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (req_event && (viol_cnt_q != CNT_MAX)) begin
            viol_cnt_d = viol_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            req_any_q     <= 1'b0;
            sys_rst_q     <= 1'b0;
            locked_q      <= 1'b0;
            cause_q       <= '0;
            first_cause_q <= '0;
            viol_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            req_any_q     <= req_any;
            // Registered from the next state so the outputs change on the same
            // edge as the state itself.
            sys_rst_q     <= (state_d == ST_HOLD);
            locked_q      <= (state_d != ST_IDLE);
            cause_q       <= cause_d;
            first_cause_q <= first_cause_d;
            viol_cnt_q    <= viol_cnt_d;
        end
    end

    assign bus.sys_rst     = sys_rst_q;
    assign bus.locked      = locked_q;
    assign bus.cause       = cause_q;
    assign bus.first_cause = first_cause_q;
    assign bus.viol_cnt    = viol_cnt_q;
    assign dbg_state_o     = state_q;

endmodule
